if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS-32 subset core. Sits directly upstream of the instruction memory and drives its byte read address from the PC.
- Captures the returned 32-bit word into the IF/ID pipeline register for the decode stage.
- Handles sequential fetch, stall, branch/jump redirect with wrong-path squash, and halt at the end of the program image.

---
 rtl/if_fetch_stage.sv | 118 +++++++++++
 tb/tb_if_fetch_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address from the PC and captures the returned word into IF/ID.
// Handles sequential fetch, stall, jump/branch redirects that squash the wrong-path word, and halt at the end of the image.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_LIMIT = 32'd124,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic        ifid_valid_o,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_pc_plus4_o,
   output logic        halted_o,
   output logic        misalign_err_o
);

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc_plus4;
   logic        r_ifid_valid;
   logic        r_halted;
   logic        r_misalign;

   logic        w_redirect;
   logic [31:0] w_target_raw;
   logic [31:0] w_target;
   logic        w_target_misaligned;
   logic [31:0] w_pc_plus4;

   // Jump wins over branch; the target is force-aligned but the misalignment is still recorded.
   always_comb begin
      w_redirect          = jump_i | branch_taken_i;
      w_target_raw        = jump_i ? jump_target_i : branch_target_i;
      w_target            = {w_target_raw[31:2], 2'b00};
      w_target_misaligned = |w_target_raw[1:0];
   end

   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_RUN;
         r_pc            <= RESET_PC;
         r_ifid_instr    <= NOP_WORD;
         r_ifid_pc       <= '0;
         r_ifid_pc_plus4 <= '0;
         r_ifid_valid    <= 1'b0;
         r_halted        <= 1'b0;
         r_misalign      <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_redirect) begin
                  r_pc         <= w_target;
                  r_ifid_valid <= 1'b0;
                  r_ifid_instr <= NOP_WORD;
                  if (w_target_misaligned) begin
                     r_misalign <= 1'b1;
                  end
               end else if (stall_i) begin
                  r_pc <= r_pc;
               end else if (r_pc >= PC_LIMIT) begin
                  r_state      <= ST_HALT;
                  r_halted     <= 1'b1;
                  r_ifid_valid <= 1'b0;
                  r_ifid_instr <= NOP_WORD;
               end else begin
                  r_ifid_instr    <= imem_instr_i;
                  r_ifid_pc       <= r_pc;
                  r_ifid_pc_plus4 <= w_pc_plus4;
                  r_ifid_valid    <= 1'b1;
                  r_pc            <= w_pc_plus4;
               end
            end
            ST_HALT: begin
               // Stall is ignored here; only a redirect can move the PC, and only an in-image target resumes fetch.
               if (w_redirect) begin
                  r_pc <= w_target;
                  if (w_target_misaligned) begin
                     r_misalign <= 1'b1;
                  end
                  if (w_target < PC_LIMIT) begin
                     r_state  <= ST_RUN;
                     r_halted <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign imem_addr_o     = r_pc;
   assign ifid_valid_o    = r_ifid_valid;
   assign ifid_instr_o    = r_ifid_instr;
   assign ifid_pc_o       = r_ifid_pc;
   assign ifid_pc_plus4_o = r_ifid_pc_plus4;
   assign halted_o        = r_halted;
   assign misalign_err_o  = r_misalign;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a behavioural fetch model queues the expected IF/ID records,
// a monitor pops them whenever the stage presents a new valid instruction.
module tb_if_fetch_stage;

   localparam logic [31:0] LIMIT = 32'd124;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        ifid_valid_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_pc_plus4_o;
   logic        halted_o;
   logic        misalign_err_o;

   if_fetch_stage #(
      .RESET_PC(32'h0000_0000),
      .PC_LIMIT(LIMIT),
      .NOP_WORD(32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .imem_addr_o     (imem_addr_o),
      .imem_instr_i    (imem_instr_i),
      .ifid_valid_o    (ifid_valid_o),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_pc_o       (ifid_pc_o),
      .ifid_pc_plus4_o (ifid_pc_plus4_o),
      .halted_o        (halted_o),
      .misalign_err_o  (misalign_err_o)
   );

   always #5 clk = ~clk;

   // Instruction memory: 64 words, zero-latency read.
   logic [31:0] mem [64];
   assign imem_instr_i = mem[imem_addr_o[7:2]];

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_t;

   fetch_t q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_halt;
   logic        m_valid;
   logic        m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_halt  = 1'b0;
      m_valid = 1'b0;
      m_mis   = 1'b0;
      q.delete();
   endtask

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_step();
      logic        redir;
      logic [31:0] tgt;
      redir = jump_i || branch_taken_i;
      tgt   = jump_i ? jump_target_i : branch_target_i;
      if (redir) begin
         if (tgt % 4 != 0) m_mis = 1'b1;
         m_pc = tgt - (tgt % 4);
         if (m_halt) begin
            if (m_pc < LIMIT) m_halt = 1'b0;
         end else begin
            m_valid = 1'b0;
         end
      end else if (!m_halt && !stall_i) begin
         if (m_pc >= LIMIT) begin
            m_halt  = 1'b1;
            m_valid = 1'b0;
         end else begin
            q.push_back('{instr: mem[(m_pc / 4) % 64], pc: m_pc});
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end
      end
   endtask

   task automatic cycle(input logic j, input logic [31:0] jt, input logic b,
                        input logic [31:0] bt, input logic s);
      jump_i          = j;
      jump_target_i   = jt;
      branch_taken_i  = b;
      branch_target_i = bt;
      stall_i         = s;
      model_step();
      @(posedge clk);
      #1;
      chk("pc", imem_addr_o, m_pc);
      chk("halted", {31'b0, halted_o}, {31'b0, m_halt});
      chk("misalign", {31'b0, misalign_err_o}, {31'b0, m_mis});
      chk("valid", {31'b0, ifid_valid_o}, {31'b0, m_valid});
      if (!m_valid) chk("squash_nop", ifid_instr_o, 32'h0);
      @(negedge clk);
      jump_i         = 1'b0;
      branch_taken_i = 1'b0;
      stall_i        = 1'b0;
   endtask

   // Monitor: a new IF/ID record appears after any non-stalled edge that leaves valid high.
   initial begin
      logic   s_stall;
      logic   s_rst;
      fetch_t e;
      forever begin
         @(posedge clk);
         s_stall = stall_i;
         s_rst   = rst_n;
         #2;
         if (s_rst && rst_n && ifid_valid_o && !s_stall) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got pc %h instr %h expected no fetch", ifid_pc_o, ifid_instr_o);
            end else begin
               e = q.pop_front();
               chk("ifid_instr", ifid_instr_o, e.instr);
               chk("ifid_pc", ifid_pc_o, e.pc);
               chk("ifid_pc_plus4", ifid_pc_plus4_o, e.pc + 32'd4);
            end
         end
      end
   end

   initial begin
      logic [31:0] t;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0001;
      rst_n = 1'b0; stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
      jump_target_i = '0; branch_target_i = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", imem_addr_o, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid_o}, 32'h0);
      chk("rst_instr", ifid_instr_o, 32'h0);
      chk("rst_ifid_pc", ifid_pc_o, 32'h0);
      chk("rst_pc4", ifid_pc_plus4_o, 32'h0);
      chk("rst_halted", {31'b0, halted_o}, 32'h0);
      chk("rst_mis", {31'b0, misalign_err_o}, 32'h0);
      rst_n = 1'b1;

      // Sequential fetch
      cycle(0, 0, 0, 0, 0);
      chk("seq1_instr", ifid_instr_o, 32'h2008_0005);
      chk("seq1_pc4", ifid_pc_plus4_o, 32'd4);
      cycle(0, 0, 0, 0, 0);
      chk("seq2_instr", ifid_instr_o, 32'h2009_0001);
      chk("seq2_pc", ifid_pc_o, 32'd4);

      // Stall at pc 8
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, 1);
         chk("stall_addr", imem_addr_o, 32'd8);
         chk("stall_hold", ifid_pc_o, 32'd4);
      end
      cycle(0, 0, 0, 0, 0);
      chk("unstall_pc", ifid_pc_o, 32'd8);

      // Branch during stall at pc 12
      cycle(0, 0, 1, 32'd40, 1);
      chk("brstall_pc", imem_addr_o, 32'd40);
      cycle(0, 0, 0, 0, 0);
      chk("brstall_ifid_pc", ifid_pc_o, 32'd40);

      // Jump/branch collision and misaligned jump
      cycle(1, 32'd64, 1, 32'd20, 0);
      chk("collide_pc", imem_addr_o, 32'd64);
      cycle(1, 32'd66, 0, 0, 0);
      chk("misjump_pc", imem_addr_o, 32'd64);
      chk("misjump_flag", {31'b0, misalign_err_o}, 32'd1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("mis_sticky", {31'b0, misalign_err_o}, 32'd1);

      // Halt at the end of the image, then resume
      cycle(1, 32'd100, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
      chk("pre_halt_pc", imem_addr_o, 32'd124);
      cycle(0, 0, 0, 0, 0);
      chk("halt_flag", {31'b0, halted_o}, 32'd1);
      chk("halt_pc", imem_addr_o, 32'd124);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 32'd200, 0);
      chk("halt_far_pc", imem_addr_o, 32'd200);
      chk("halt_far_flag", {31'b0, halted_o}, 32'd1);
      cycle(1, 32'd0, 0, 0, 0);
      chk("resume_flag", {31'b0, halted_o}, 32'd0);
      cycle(0, 0, 0, 0, 0);
      chk("resume_ifid_pc", ifid_pc_o, 32'd0);

      // Asynchronous reset mid-cycle at pc 52
      cycle(1, 32'd52, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", imem_addr_o, 32'h0);
      chk("arst_valid", {31'b0, ifid_valid_o}, 32'h0);
      chk("arst_instr", ifid_instr_o, 32'h0);
      chk("arst_ifid_pc", ifid_pc_o, 32'h0);
      chk("arst_mis", {31'b0, misalign_err_o}, 32'h0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic        j, b, s;
         logic [31:0] jt, bt;
         j  = ($urandom_range(0, 99) < 5);
         b  = ($urandom_range(0, 99) < 8);
         s  = ($urandom_range(0, 99) < 20);
         jt = $urandom_range(0, 160);
         bt = $urandom_range(0, 160);
         if ($urandom_range(0, 19) == 0) begin
            t  = $urandom;
            jt = t;
         end
         cycle(j, jt, b, bt, s);
      end

      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      chk("sb_drain", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
